// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display scan-out reads take PixEn slots, frame-loader
// writes take the rest, and the displayed bank only changes at the start of vertical blanking.
module vram_arbiter #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned BANK_W   = 2,
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     PixEn,
    input  logic [10:0]              Col,
    input  logic [10:0]              Row,
    input  logic [BANK_W-1:0]        DispBankReq,
    input  logic                     WrReq,
    input  logic [BANK_W+ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0]        WrData,
    output logic                     WrAck,
    output logic                     WrDrop,
    output logic [BANK_W+ADDR_W-1:0] Mem_Addr,
    output logic                     Mem_We,
    output logic [DATA_W-1:0]        Mem_Wdata,
    input  logic [DATA_W-1:0]        Mem_Rdata,
    output logic [DATA_W-1:0]        Pixel,
    output logic                     PixelValid,
    output logic                     FrameStart,
    output logic [BANK_W-1:0]        DispBank
);

    localparam int unsigned MA_W      = BANK_W + ADDR_W;
    localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DISP  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [MA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              drop_q, drop_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              fs_q, fs_d;
    logic [RD_LAT:0]   tok_vld_q, tok_vld_d;
    logic [RD_LAT:0]   tok_act_q, tok_act_d;
    logic [DATA_W-1:0] pixel_q, pixel_d;
    logic              pv_q, pv_d;

    logic              active_c;
    logic              disp_slot_c;
    logic              wr_ok_c;
    logic              switch_c;
    logic [ADDR_W-1:0] pix_off_c;

    always_comb begin
        active_c    = (Col < 11'(H_ACTIVE)) && (Row < 11'(V_ACTIVE));
        disp_slot_c = PixEn && active_c;
        wr_ok_c     = {1'b0, WrAddr[ADDR_W-1:0]} < (ADDR_W+1)'(FRAME_PIX);
        switch_c    = PixEn && (Row == 11'(V_ACTIVE)) && (Col == 11'd0);
        // Only consumed in an active slot, where it stays below FRAME_PIX.
        pix_off_c   = ADDR_W'(Row) * ADDR_W'(H_ACTIVE) + ADDR_W'(Col);
    end

    // Slot decision: display read beats write; idle holds the address.
    always_comb begin
        state_d   = ST_IDLE;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack_d     = 1'b0;
        drop_d    = 1'b0;
        bank_d    = bank_q;
        fs_d      = 1'b0;
        tok_vld_d = {tok_vld_q[RD_LAT-1:0], PixEn};
        tok_act_d = {tok_act_q[RD_LAT-1:0], disp_slot_c};
        pixel_d   = pixel_q;
        pv_d      = tok_vld_q[RD_LAT];

        if (disp_slot_c) begin
            state_d = ST_DISP;
            addr_d  = {bank_q, pix_off_c};
        end else if (WrReq) begin
            ack_d = 1'b1;
            if (wr_ok_c) begin
                state_d = ST_WRITE;
                addr_d  = WrAddr;
                wdata_d = WrData;
            end else begin
                drop_d = 1'b1;
            end
        end

        if (switch_c) begin
            bank_d = DispBankReq;
            fs_d   = 1'b1;
        end

        // Token at the end of the delay line lines up with that read's Mem_Rdata.
        if (tok_vld_q[RD_LAT]) begin
            pixel_d = tok_act_q[RD_LAT] ? Mem_Rdata : '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            drop_q    <= 1'b0;
            bank_q    <= '0;
            fs_q      <= 1'b0;
            tok_vld_q <= '0;
            tok_act_q <= '0;
            pixel_q   <= '0;
            pv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack_q     <= ack_d;
            drop_q    <= drop_d;
            bank_q    <= bank_d;
            fs_q      <= fs_d;
            tok_vld_q <= tok_vld_d;
            tok_act_q <= tok_act_d;
            pixel_q   <= pixel_d;
            pv_q      <= pv_d;
        end
    end

    assign Mem_Addr   = addr_q;
    assign Mem_We     = (state_q == ST_WRITE);
    assign Mem_Wdata  = wdata_q;
    assign WrAck      = ack_q;
    assign WrDrop     = drop_q;
    assign DispBank   = bank_q;
    assign FrameStart = fs_q;
    assign Pixel      = pixel_q;
    assign PixelValid = pv_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus a randomized phase, all outputs
// compared every cycle against a slot/queue-based reference model with its own memory image.
module tb_vram_arbiter;

    localparam int H     = 640;
    localparam int V     = 480;
    localparam int AW    = 19;
    localparam int BW    = 2;
    localparam int DW    = 24;
    localparam int RL    = 1;
    localparam int MW    = AW + BW;
    localparam int FRAME = H * V;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_en = 1'b0;
    logic [10:0]   col_s, row_s;
    logic [BW-1:0] disp_bank_req = '0;
    logic          wr_req = 1'b0;
    logic [MW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack, wr_drop, mem_we, pixel_valid, frame_start;
    logic [MW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, pixel;
    logic [DW-1:0] mem_rdata = '0;
    logic [BW-1:0] disp_bank;

    int row_i = 0;
    int col_i = 0;
    bit rand_rows = 1'b0;
    int rows_tbl [9] = '{0, 1, 2, 100, 479, 480, 481, 523, 700};

    assign row_s = 11'(row_i);
    assign col_s = 11'(col_i);

    always #5 clk = ~clk;

    vram_arbiter #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .BANK_W(BW), .DATA_W(DW), .RD_LAT(RL)
    ) dut (
        .Clk(clk), .Rst_n(rst_n), .PixEn(pix_en), .Col(col_s), .Row(row_s),
        .DispBankReq(disp_bank_req), .WrReq(wr_req), .WrAddr(wr_addr), .WrData(wr_data),
        .WrAck(wr_ack), .WrDrop(wr_drop), .Mem_Addr(mem_addr), .Mem_We(mem_we),
        .Mem_Wdata(mem_wdata), .Mem_Rdata(mem_rdata), .Pixel(pixel), .PixelValid(pixel_valid),
        .FrameStart(frame_start), .DispBank(disp_bank)
    );

    typedef struct {
        int          due;
        logic        act;
        logic [DW-1:0] val;
    } tok_t;

    logic [DW-1:0] ram     [logic [MW-1:0]];
    logic [DW-1:0] ref_mem [logic [MW-1:0]];
    logic [DW-1:0] rdq [$];
    tok_t          pq  [$];

    logic [MW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_pix = '0;
    logic          e_we = 1'b0, e_ack = 1'b0, e_drop = 1'b0, e_fs = 1'b0, e_pv = 1'b0;
    logic [BW-1:0] e_bank = '0;
    int            cyc = 0;
    int            n_chk = 0, n_pass = 0, n_fail = 0;

    function automatic logic [DW-1:0] dflt(input logic [MW-1:0] a);
        logic [31:0] h;
        h = 32'(a) * 32'h9E37_79B1;
        return h[31:8];
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [MW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: RAM environment, reference decision, edge, compare, scan advance.
    task automatic tick();
        logic          act;
        logic [MW-1:0] a;
        tok_t          tk;
        if (mem_we) ram[mem_addr] = mem_wdata;
        rdq.push_back(ram.exists(mem_addr) ? ram[mem_addr] : dflt(mem_addr));

        act = (col_i < H) && (row_i < V);
        if (!rst_n) begin
            e_addr = '0; e_we = 1'b0; e_wdata = '0; e_ack = 1'b0; e_drop = 1'b0;
            e_fs = 1'b0; e_bank = '0; e_pix = '0;
            pq.delete();
        end else begin
            e_we = 1'b0; e_ack = 1'b0; e_drop = 1'b0; e_fs = 1'b0;
            if (pix_en && act) begin
                a = {e_bank, AW'(row_i * H + col_i)};
                e_addr = a;
                pq.push_back('{due: cyc + RL + 2, act: 1'b1, val: ref_rd(a)});
            end else begin
                if (pix_en) pq.push_back('{due: cyc + RL + 2, act: 1'b0, val: '0});
                if (wr_req) begin
                    e_ack = 1'b1;
                    if (int'(wr_addr[AW-1:0]) < FRAME) begin
                        e_we = 1'b1;
                        e_addr = wr_addr;
                        e_wdata = wr_data;
                        ref_mem[wr_addr] = wr_data;
                    end else begin
                        e_drop = 1'b1;
                    end
                end
            end
            if (pix_en && row_i == V && col_i == 0) begin
                e_bank = disp_bank_req;
                e_fs = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        if (rdq.size() >= RL) mem_rdata = rdq.pop_front();

        e_pv = 1'b0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            tk = pq.pop_front();
            e_pv = 1'b1;
            e_pix = tk.act ? tk.val : '0;
        end

        chk("mem_addr",    64'(mem_addr),    64'(e_addr));
        chk("mem_we",      64'(mem_we),      64'(e_we));
        chk("mem_wdata",   64'(mem_wdata),   64'(e_wdata));
        chk("wr_ack",      64'(wr_ack),      64'(e_ack));
        chk("wr_drop",     64'(wr_drop),     64'(e_drop));
        chk("frame_start", 64'(frame_start), 64'(e_fs));
        chk("disp_bank",   64'(disp_bank),   64'(e_bank));
        chk("pixel_valid", 64'(pixel_valid), 64'(e_pv));
        chk("pixel",       64'(pixel),       64'(e_pix));

        if (pix_en) begin
            col_i++;
            if (col_i >= 795) begin
                col_i = 0;
                row_i = rand_rows ? rows_tbl[$urandom_range(0, 8)] : (row_i + 1) % 524;
            end
        end
        pix_en = ~pix_en;
    endtask

    task automatic align_pix();
        if (!pix_en) tick();
    endtask

    task automatic new_write();
        int off;
        wr_data = DW'($urandom);
        case ($urandom_range(0, 3))
            0, 1:    off = int'($urandom_range(0, FRAME - 1));
            2:       off = 640 * int'($urandom_range(0, 2)) + int'($urandom_range(0, 639));
            default: off = int'($urandom_range(FRAME, 524287));
        endcase
        wr_addr = {BW'($urandom), AW'(off)};
    endtask

    initial begin
        ram[{2'd0, 19'd641}]     = 24'hABCDEF;
        ref_mem[{2'd0, 19'd641}] = 24'hABCDEF;

        // Reset, then sweep the bottom of a frame and blanking with no writes.
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        row_i = 478; col_i = 0;
        repeat (4 * 795 * 2) tick();

        // Preloaded pixel at row 1, col 1 of bank 0.
        align_pix();
        row_i = 1; col_i = 1;
        tick();
        repeat (RL + 1) tick();
        chk("pix641", 64'(pixel), 64'h00AB_CDEF);
        chk("pix641_valid", 64'(pixel_valid), 64'd1);

        // Write colliding with an active display slot.
        align_pix();
        row_i = 10; col_i = 5;
        wr_req = 1'b1; wr_addr = {2'd1, 19'd100}; wr_data = 24'h123456;
        tick();
        chk("collide_ack_held", 64'(wr_ack), 64'd0);
        chk("collide_disp_we",  64'(mem_we), 64'd0);
        tick();
        chk("collide_ack",  64'(wr_ack),   64'd1);
        chk("collide_we",   64'(mem_we),   64'd1);
        chk("collide_addr", 64'(mem_addr), 64'({2'd1, 19'd100}));
        wr_req = 1'b0;
        repeat (6) tick();

        // Offset exactly one past the frame is dropped.
        row_i = 600; col_i = 0;
        wr_req = 1'b1; wr_addr = {2'd3, 19'd307200};
        tick();
        chk("drop_ack",  64'(wr_ack),  64'd1);
        chk("drop_flag", 64'(wr_drop), 64'd1);
        chk("drop_we",   64'(mem_we),  64'd0);
        wr_req = 1'b0;

        // Bank request mid-frame only lands at row 480, col 0.
        disp_bank_req = 2'd2;
        row_i = 100; col_i = 0;
        repeat (20) tick();
        chk("bank_not_yet", 64'(disp_bank), 64'd0);
        align_pix();
        row_i = 480; col_i = 0;
        tick();
        chk("bank_switched", 64'(disp_bank),   64'd2);
        chk("bank_fs",       64'(frame_start), 64'd1);
        disp_bank_req = 2'd0;
        align_pix();
        row_i = 5; col_i = 3;
        tick();
        chk("bank2_read_addr", 64'(mem_addr), 64'({2'd2, 19'(5 * 640 + 3)}));
        chk("bank_held", 64'(disp_bank), 64'd2);

        // Reset in the middle of a write burst.
        row_i = 200; col_i = 0;
        wr_req = 1'b1;
        new_write();
        for (int i = 0; i < 8; i++) begin
            if (e_ack) new_write();
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("rst_addr",  64'(mem_addr),    64'd0);
        chk("rst_we",    64'(mem_we),      64'd0);
        chk("rst_wdata", 64'(mem_wdata),   64'd0);
        chk("rst_ack",   64'(wr_ack),      64'd0);
        chk("rst_drop",  64'(wr_drop),     64'd0);
        chk("rst_pixel", 64'(pixel),       64'd0);
        chk("rst_pv",    64'(pixel_valid), 64'd0);
        chk("rst_fs",    64'(frame_start), 64'd0);
        chk("rst_bank",  64'(disp_bank),   64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (e_ack) new_write();
            tick();
        end

        // Randomized traffic over a mix of active, blanking and out-of-range rows.
        rand_rows = 1'b1;
        row_i = 0; col_i = 0;
        for (int i = 0; i < 14000; i++) begin
            if (!wr_req || e_ack) begin
                wr_req = ($urandom_range(0, 2) != 0);
                new_write();
            end
            if ($urandom_range(0, 499) == 0) disp_bank_req = BW'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port video RAM between the display scan-out (read) path and a frame-loader (write) requester, and selects which frame bank is displayed. Sits between the VGA scan counters and the video RAM, on the system clock `Clk`; the pixel-rate strobe marks display slots. Display reads never stall; writes take the remaining cycles. Bank changes take effect only at the start of vertical blanking, so a displayed frame never tears.

## Interface
- `H_ACTIVE`, 640, visible columns
- `V_ACTIVE`, 480, visible rows
- `ADDR_W`, 19, in-bank address width (H_ACTIVE*V_ACTIVE ≤ 2^ADDR_W)
- `BANK_W`, 2, bank-select width
- `DATA_W`, 24, pixel width (8R/8G/8B)
- `RD_LAT`, 1, RAM read latency in Clk cycles (≥1)

Ports:
- `Clk`  in  1  system clock
- `Rst_n`  in  1  reset, synchronous, active-low
- `PixEn`  in  1  pixel strobe, one Clk cycle in two
- `Col`  in  11  scan column, sampled on PixEn
- `Row`  in  11  scan row, sampled on PixEn
- `DispBankReq`  in  BANK_W  requested display bank
- `WrReq`  in  1  write request, held until WrAck
- `WrAddr`  in  BANK_W+ADDR_W  {bank, offset}
- `WrData`  in  DATA_W  write data
- `WrAck`  out  1  one-cycle pulse: write issued or dropped
- `WrDrop`  out  1  one-cycle pulse with WrAck: offset out of range, not written
- `Mem_Addr`  out  BANK_W+ADDR_W  RAM address, registered
- `Mem_We`  out  1  RAM write enable, registered
- `Mem_Wdata`  out  DATA_W  RAM write data, registered
- `Mem_Rdata`  in  DATA_W  RAM read data, RD_LAT cycles after address
- `Pixel`  out  DATA_W  display pixel, registered
- `PixelValid`  out  1  Pixel strobe, one per PixEn
- `FrameStart`  out  1  one-cycle pulse at the bank-switch point
- `DispBank`  out  BANK_W  currently displayed bank

## Operation
- Active area: `Col < H_ACTIVE && Row < V_ACTIVE`. Everything else, including out-of-range counters, is blanking.
- Slot decision each cycle, with priority from highest to lowest:
  - `PixEn && active`: display read, `Mem_Addr = {DispBank, Row*H_ACTIVE+Col}`, `Mem_We = 0`.
  - `WrReq`:
    - If offset < H_ACTIVE*V_ACTIVE: write, `Mem_Addr = WrAddr`, `Mem_We = 1`, `Mem_Wdata = WrData`, WrAck pulse.
    - Otherwise: `Mem_We = 0`, WrAck and WrDrop pulse.
  - Idle: `Mem_We = 0`, Mem_Addr holds.
- Internal FSM, states IDLE / DISP / WRITE, reflects the registered slot type. The next state is re-evaluated every cycle, with no dwell.
- Write handshake:
  - WrAck is asserted in the cycle Mem_We=1 is presented.
  - The requester may change WrAddr/WrData the cycle after WrAck.
  - Holding WrReq high gives back-to-back writes on every non-display cycle.
- Display pipeline:
  - On every PixEn, a token carrying `active` enters a delay line of RD_LAT+1 stages.
  - At the output: active gives `Pixel = Mem_Rdata`, blanking gives `Pixel = 0`. PixelValid pulses in both cases.
- Address arithmetic is unsigned. `Row*H_ACTIVE+Col` is computed at ADDR_W bits, evaluated only when active, so it never overflows.
- Bank switch: on `PixEn && Row == V_ACTIVE && Col == 0`:
  - DispBank ← DispBankReq.
  - FrameStart pulses with the registered update.
  - DispBankReq changes at any other time have no effect until the next switch point.
- Writes to the displayed bank are legal; tearing in that case is the writer's concern.

## Timing
- Reset (`Rst_n = 0` at a Clk edge) clears the following; the pipeline token line is cleared too:
  - Outputs to 0: Mem_Addr, Mem_We, Mem_Wdata, Pixel, PixelValid, WrAck, WrDrop, FrameStart, DispBank.
  - FSM to IDLE.
- Reset mid-write: a pending request is not acked. The requester re-presents it after reset.
- Decision to Mem_* outputs: 1 cycle.
- PixEn to Pixel/PixelValid: RD_LAT+2 cycles, fixed, in both active and blanking.
- Write latency: WrReq to WrAck is 1 cycle if no display slot collides, 2 cycles at most.
- Simultaneous `PixEn && active` and WrReq: display wins and the write goes next cycle. PixEn alternates, so the next cycle is guaranteed free.
- Bank switch coincident with WrReq: both proceed; the write uses its own bank bits.

## Test plan
- Reset release with WrReq=0 and counters sweeping a full frame (795×524): PixelValid pulses every 2nd cycle; Pixel=0 in blanking; Mem_We never 1.
- RAM preloaded, bank 0 offset 641 = 0xABCDEF. When (Row=1, Col=1) is sampled on PixEn, Pixel=0xABCDEF appears RD_LAT+2 cycles later.
- WrReq held with WrAddr={1, 100}, WrData=0x123456, asserted on a PixEn active cycle: WrAck comes 2 cycles later, Mem_We=1, Mem_Addr={1,100}. No display slot is lost.
- WrAddr offset 307200: WrAck and WrDrop pulse together, and Mem_We stays 0.
- DispBankReq=2 driven at Row=100: DispBank stays 0 until Row=480, Col=0, PixEn. It then becomes 2 with a FrameStart pulse. Subsequent reads use bank-2 addresses.
- Rst_n low for 1 cycle during a burst of writes: all outputs are 0 the next cycle. No WrAck is issued for the interrupted request, and normal operation resumes after release.
